// File: rtl/priority_encoder_8to3.sv
// Registered 8-line priority encoder with a sticky pending vector and a
// valid/ready output slot; grants are selected only from registered state.
module priority_encoder_8to3 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       idle
);

    logic [7:0] p_q, p_d;
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;

    logic       slot_free;
    logic       grant;
    logic [2:0] sel_idx;
    logic [7:0] clr;

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        sel_idx = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (p_q[i]) sel_idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (p_q[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        slot_free = !valid_q || ready;
        grant     = slot_free && (p_q != 8'h00);
        clr       = grant ? (8'h01 << sel_idx) : 8'h00;
        // New requests win over the clear of the line granted this cycle.
        p_d       = (p_q & ~clr) | req;
        code_d    = grant ? sel_idx : code_q;
        valid_d   = slot_free ? (p_q != 8'h00) : valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= 8'h00;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = p_q;
    assign idle    = (p_q == 8'h00) && !valid_q;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench: two encoders (high-first and low-first) share stimulus.
module tb_priority_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic [2:0] code_h, code_l;
    logic       valid_h, valid_l;
    logic [7:0] pend_h, pend_l;
    logic       idle_h, idle_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_encoder_8to3 #(.HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_h), .valid(valid_h), .pending(pend_h), .idle(idle_h)
    );

    priority_encoder_8to3 #(.HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .code(code_l), .valid(valid_l), .pending(pend_l), .idle(idle_l)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; ready = 1'b1;
        step(); step();
        chk("rst_p_h", pend_h, 8'h00);
        chk("rst_code_h", {5'd0, code_h}, 8'd0);
        chk("rst_valid_h", {7'd0, valid_h}, 8'd0);
        chk("rst_idle_h", {7'd0, idle_h}, 8'd1);
        chk("rst_idle_l", {7'd0, idle_l}, 8'd1);

        // single request latency
        rst = 1'b0; req = 8'h10; ready = 1'b1;
        step();
        chk("lat_p", pend_h, 8'h10);
        chk("lat_valid0", {7'd0, valid_h}, 8'd0);
        chk("lat_idle0", {7'd0, idle_h}, 8'd0);
        req = 8'h00;
        step();
        chk("lat_code", {5'd0, code_h}, 8'd4);
        chk("lat_valid1", {7'd0, valid_h}, 8'd1);
        chk("lat_p_clr", pend_h, 8'h00);
        step();
        chk("lat_valid_end", {7'd0, valid_h}, 8'd0);
        chk("lat_idle_end", {7'd0, idle_h}, 8'd1);
        chk("lat_code_hold", {5'd0, code_h}, 8'd4);

        // priority order
        req = 8'h25;
        step();
        chk("pri_p", pend_h, 8'h25);
        req = 8'h00;
        step();
        chk("pri_h0", {5'd0, code_h}, 8'd5);
        chk("pri_l0", {5'd0, code_l}, 8'd0);
        chk("pri_v0", {6'd0, valid_h, valid_l}, 8'd3);
        step();
        chk("pri_h1", {5'd0, code_h}, 8'd2);
        chk("pri_l1", {5'd0, code_l}, 8'd2);
        step();
        chk("pri_h2", {5'd0, code_h}, 8'd0);
        chk("pri_l2", {5'd0, code_l}, 8'd5);
        chk("pri_v2", {6'd0, valid_h, valid_l}, 8'd3);
        step();
        chk("pri_vend", {6'd0, valid_h, valid_l}, 8'd0);

        // backpressure
        ready = 1'b0; req = 8'h81;
        step();
        chk("bp_p", pend_h, 8'h81);
        req = 8'h00;
        step();
        chk("bp_lo_code", {5'd0, code_l}, 8'd0);
        chk("bp_lo_p", pend_l, 8'h80);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_code", {5'd0, code_h}, 8'd7);
            chk("bp_hold_valid", {7'd0, valid_h}, 8'd1);
            chk("bp_hold_p", pend_h, 8'h01);
            step();
        end
        ready = 1'b1;
        step();
        chk("bp_next_code", {5'd0, code_h}, 8'd0);
        chk("bp_next_valid", {7'd0, valid_h}, 8'd1);
        chk("bp_next_p", pend_h, 8'h00);
        step();
        chk("bp_end_valid", {7'd0, valid_h}, 8'd0);

        // re-request on grant
        req = 8'h08;
        step();
        chk("rr_p", pend_h, 8'h08);
        step();
        chk("rr_code0", {5'd0, code_h}, 8'd3);
        chk("rr_p_keep", pend_h, 8'h08);
        req = 8'h00;
        step();
        chk("rr_code1", {5'd0, code_h}, 8'd3);
        chk("rr_valid1", {7'd0, valid_h}, 8'd1);
        chk("rr_p_clr", pend_h, 8'h00);
        step();
        chk("rr_end", {7'd0, valid_h}, 8'd0);

        // late high-priority arrival
        req = 8'h03;
        step();
        chk("late_p", pend_h, 8'h03);
        req = 8'h40;
        step();
        chk("late_c0", {5'd0, code_h}, 8'd1);
        chk("late_p1", pend_h, 8'h41);
        req = 8'h00;
        step();
        chk("late_c1", {5'd0, code_h}, 8'd6);
        step();
        chk("late_c2", {5'd0, code_h}, 8'd0);
        chk("late_v2", {7'd0, valid_h}, 8'd1);
        step();
        chk("late_end", {7'd0, valid_h}, 8'd0);

        // reset mid-operation
        ready = 1'b0; req = 8'hFF;
        step();
        step();
        chk("mrst_pre_p", pend_h, 8'hFF);
        chk("mrst_pre_v", {7'd0, valid_h}, 8'd1);
        chk("mrst_pre_c", {5'd0, code_h}, 8'd7);
        rst = 1'b1;
        step();
        chk("mrst_p", pend_h, 8'h00);
        chk("mrst_v", {6'd0, valid_h, valid_l}, 8'd0);
        chk("mrst_c", {5'd0, code_h}, 8'd0);
        chk("mrst_idle", {6'd0, idle_h, idle_l}, 8'd3);
        rst = 1'b0; req = 8'h01; ready = 1'b1;
        step();
        chk("post_rst_p", pend_h, 8'h01);
        req = 8'h00;
        step();
        chk("post_rst_c", {5'd0, code_h}, 8'd0);
        chk("post_rst_v", {7'd0, valid_h}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_encoder_8to3.md
PRIORITY_ENCODER_8TO3 -- requirements
Module: priority_encoder_8to3

Interface
REQ-001 The block SHALL have parameter HIGH_FIRST, default 1: 1 = index 7 has highest priority, 0 = index 0 has highest priority.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: request lines; bit i high in a cycle = one request for line i.
REQ-005 The block SHALL have port code, output, 3 bits: encoded index of the granted line, registered.
REQ-006 The block SHALL have port valid, output, 1 bit: code holds a grant not yet accepted, registered.
REQ-007 The block SHALL have port ready, input, 1 bit: consumer accepts code on any edge where valid and ready are both high.
REQ-008 The block SHALL have port pending, output, 8 bits: registered pending-request vector P.
REQ-009 The block SHALL have port idle, output, 1 bit: combinational (P == 0) and not valid.

Function
REQ-010 The block SHALL keep an 8-bit pending register P, with P_next = (P & ~clr) | req, where clr is the one-hot bit of the line granted this cycle (0 if no grant).
REQ-011 The block SHALL treat the output slot as free in a cycle when valid = 0 or (valid = 1 and ready = 1).
REQ-012 On each edge with a free slot and P != 0, the block SHALL load code with the priority index of P (per HIGH_FIRST), set valid = 1, and assert clr for that index.
REQ-013 On each edge with a free slot and P == 0, the block SHALL set valid = 0 and leave code at its previous value.
REQ-014 While valid = 1 and ready = 0, the block SHALL hold code and valid stable and clear no bit of P.
REQ-015 The block SHALL select grants from registered P only, never directly from same-cycle req.
- Minimum latency: req bit sampled at edge N -> P bit set after N -> valid/code after edge N+1.
REQ-016 If req[i] is high in the same cycle that line i is granted, the block SHALL leave P[i] = 1, since the new request takes priority over the clear.
REQ-017 The block SHALL merge repeated requests on a line that is already pending: no counting, no overflow, no error flag.
REQ-018 With ready held high and P continuously nonempty, the block SHALL issue one grant per cycle: back-to-back valid with no bubble.
REQ-019 The block SHALL re-evaluate priority at every grant.
- A higher-priority request arriving while lower-priority lines are pending is granted next.
- Starvation of low-priority lines is permitted.
REQ-020 The block SHALL carry no combinational path from req or ready to code or valid.
REQ-021 The block SHALL keep the priority selection purely combinational over P, computed within one cycle.

Reset
REQ-022 While rst = 1 at an edge, the block SHALL set P = 8'h00, code = 3'd0 and valid = 0, ignoring req and ready.
REQ-023 When rst asserts mid-operation, the block SHALL discard all pending requests and any unaccepted grant.
REQ-024 On the first edge after rst deasserts, the block SHALL sample req normally.
REQ-025 After reset, idle SHALL read 1 until a request is captured.

Verification
REQ-026 The bench SHALL cover single request latency: reset; req = 8'h10 for one cycle with ready = 1 -> P = 8'h10 after edge N, then code = 3'd4 and valid = 1 after edge N+1, then valid = 0 and idle = 1.
REQ-027 The bench SHALL cover priority order: req = 8'h25 for one cycle with ready = 1 and HIGH_FIRST = 1 -> codes 5, 2, 0 on consecutive cycles, then valid = 0; with HIGH_FIRST = 0 -> codes 0, 2, 5.
REQ-028 The bench SHALL cover backpressure: P = 8'h81 with ready = 0 -> code = 7 and valid = 1 held for 5 cycles with P = 8'h01 unchanged; ready = 1 -> code 0 accepted next, then valid = 0.
REQ-029 The bench SHALL cover re-request on grant: req[3] high on the same cycle line 3 is granted -> P[3] stays 1, and code 3 is issued again on the next grant.
REQ-030 The bench SHALL cover late high-priority arrival: P = 8'h03 draining with ready = 1; req = 8'h40 mid-drain -> code 6 issued before remaining line 0.
REQ-031 The bench SHALL cover reset mid-operation: P = 8'hFF and valid = 1, assert rst for one cycle with req = 8'hFF -> P = 0, valid = 0, code = 0, idle = 1 after the edge.
